uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter START_TIMEOUT, default 4096: clk cycles allowed between txStart rising and txBusy seen high.
REQ-002 SHALL have parameter TIMEOUT_W, default 16: timeout counter width; START_TIMEOUT < 2**TIMEOUT_W.
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 req0  input  1  requester 0 has a byte to send (level).
REQ-006 data0  input  8  requester 0 byte, stable while req0 high.
REQ-007 ack0  output  1  one-cycle pulse: requester 0 byte completed.
REQ-008 req1  input  1  requester 1 has a byte to send (level).
REQ-009 data1  input  8  requester 1 byte, stable while req1 high.
REQ-010 ack1  output  1  one-cycle pulse: requester 1 byte completed.
REQ-011 grant  output  2  one-hot current owner; 2'b00 when idle.
REQ-012 txEn  output  1  to Uart8 txEn.
REQ-013 txStart  output  1  to Uart8 txStart.
REQ-014 txByte  output  8  to Uart8 in.
REQ-015 txBusy  input  1  from Uart8 txBusy.
REQ-016 txDone  input  1  from Uart8 txDone.
REQ-017 err  output  1  one-cycle pulse: start timeout.

Function
REQ-018 States: IDLE, START, SEND, DONE; all outputs registered.
REQ-019 IDLE: grant=00, txEn=0, txStart=0; when any req high, select winner per REQ-027/028, latch its data into txByte, set grant, go START next cycle.
REQ-020 START: txEn=1, txStart=1, txByte held; timeout counter increments each cycle.
REQ-021 START -> SEND on first cycle txBusy=1; txStart drops to 0 that same transition, so Uart8 sends exactly one byte.
REQ-022 START -> IDLE when counter reaches START_TIMEOUT without txBusy: err pulses 1 cycle, no ack, grant cleared, pointer unchanged.
REQ-023 SEND: txEn=1, txStart=0; wait for txDone=1; no timeout in SEND.
REQ-024 SEND -> DONE on txDone=1; DONE lasts exactly 1 cycle, pulses ack of granted requester, updates priority pointer, returns IDLE.
REQ-025 Minimum IDLE dwell 1 cycle between bytes; back-to-back byte latency from ack to next txStart = 2 cycles.
REQ-026 Requester dropping req after grant does not abort; byte completes and ack still pulses.
REQ-027 Simultaneous req0 and req1 in IDLE: winner per configuration (REQ-033/034).
REQ-028 Single request: granted regardless of pointer.
REQ-029 txDone or txBusy in IDLE ignored; txDone in START ignored.
REQ-030 ack0, ack1, err mutually exclusive; never asserted outside DONE/timeout cycle.

Reset
REQ-031 reset high at clock edge: state=IDLE, grant=00, txEn=0, txStart=0, txByte=8'h00, ack0=ack1=err=0, counter=0, pointer=requester 0; applies mid-transfer with no ack issued.
REQ-032 reset has priority over all other inputs.

Configuration
REQ-033 UART_TX_ARB_ROUND_ROBIN_EN defined: on contention the requester not served last wins; pointer flips only in DONE.
REQ-034 UART_TX_ARB_ROUND_ROBIN_EN undefined: fixed priority, req0 always wins contention; pointer logic absent.

Verification
REQ-035 req0=1, data0=8'h7A, Uart8 at 9600 baud, 12 MHz -> grant=01, txByte=8'h7A, single frame on tx, one ack0 pulse, Uart8 peer rxByte=8'h7A.
REQ-036 req0 and req1 held high, data0=8'hB1, data1=8'h3C, round-robin build -> frames alternate B1,3C,B1,3C; fixed build -> only B1 frames while req0 high.
REQ-037 txBusy tied 0, START_TIMEOUT=16 -> err pulses exactly 17 cycles after START entry, no ack, grant returns 00.
REQ-038 reset pulsed 1 cycle during SEND -> next cycle all outputs at reset values, no ack0/ack1.
REQ-039 req1 pulsed 1 cycle then dropped, data1=8'h55 held -> byte 8'h55 still sent, ack1 pulses once.
REQ-040 txStart high for at most START_TIMEOUT cycles per grant and never high in SEND, checked by assertion across all scenarios.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter in front of a Uart8 transmitter: grants one byte at a time, supervises start handshake.
// Build option: define UART_TX_ARB_ROUND_ROBIN_EN for round-robin contention; default is fixed priority (req0 wins).
module uart_tx_arbiter #(
  parameter int START_TIMEOUT = 4096,
  parameter int TIMEOUT_W     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic [1:0] grant,
  output logic       txEn,
  output logic       txStart,
  output logic [7:0] txByte,
  input  logic       txBusy,
  input  logic       txDone,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, START, SEND, DONE} state_t;

  state_t               r_state;
  logic [TIMEOUT_W-1:0] r_cnt;
  logic                 w_pick1;

`ifdef UART_TX_ARB_ROUND_ROBIN_EN
  logic r_ptr;  // 1: requester 1 preferred on the next contention
  assign w_pick1 = req1 & (~req0 | r_ptr);
`else
  assign w_pick1 = req1 & ~req0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      grant   <= 2'b00;
      txEn    <= 1'b0;
      txStart <= 1'b0;
      txByte  <= 8'h00;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      err     <= 1'b0;
`ifdef UART_TX_ARB_ROUND_ROBIN_EN
      r_ptr   <= 1'b0;
`endif
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req0 | req1) begin
            grant   <= w_pick1 ? 2'b10 : 2'b01;
            txByte  <= w_pick1 ? data1 : data0;
            txEn    <= 1'b1;
            txStart <= 1'b1;
            r_cnt   <= '0;
            r_state <= START;
          end
        end
        START: begin
          if (txBusy) begin
            txStart <= 1'b0;
            r_cnt   <= '0;
            r_state <= SEND;
          end else if (r_cnt == TIMEOUT_W'(START_TIMEOUT)) begin
            err     <= 1'b1;
            grant   <= 2'b00;
            txEn    <= 1'b0;
            txStart <= 1'b0;
            r_cnt   <= '0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            // Drop txStart once the budget is spent; the final cycle only waits for a late txBusy.
            if (r_cnt == TIMEOUT_W'(START_TIMEOUT - 1)) txStart <= 1'b0;
          end
        end
        SEND: begin
          if (txDone) begin
            txEn    <= 1'b0;
            ack0    <= grant[0];
            ack1    <= grant[1];
            r_state <= DONE;
          end
        end
        DONE: begin
          grant   <= 2'b00;
          r_state <= IDLE;
`ifdef UART_TX_ARB_ROUND_ROBIN_EN
          r_ptr   <= grant[0];
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: timestamp-based protocol model, per-cycle compare, Uart8 responder, directed scenarios.
module tb_uart_tx_arbiter;
  localparam int ST = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic       ack0, ack1, err, txEn, txStart;
  logic [1:0] grant;
  logic [7:0] txByte;
  logic       r_busy = 1'b0, r_done = 1'b0, f_busy = 1'b0, f_done = 1'b0;
  logic       txBusy, txDone;
  assign txBusy = r_busy | f_busy;
  assign txDone = r_done | f_done;

  uart_tx_arbiter #(.START_TIMEOUT(ST), .TIMEOUT_W(16)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .data0(data0), .ack0(ack0),
    .req1(req1), .data1(data1), .ack1(ack1),
    .grant(grant), .txEn(txEn), .txStart(txStart), .txByte(txByte),
    .txBusy(txBusy), .txDone(txDone), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: each grant is described by the cycle it began (tg), the first SEND
  // cycle (tb) and the DONE cycle (td); outputs follow from those timestamps.
  int cyc = 0, m_own = -1, m_tg = 0, m_tb = -1, m_td = -1, m_err_at = -1, m_ptr = 0;
  logic [7:0] m_byte = 8'h00;
  bit m_en = 0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_own = -1; m_tb = -1; m_td = -1; m_err_at = -1; m_ptr = 0; m_byte = 8'h00; m_en = 1;
    end else if (m_own < 0) begin
      if (req0 | req1) begin
`ifdef UART_TX_ARB_ROUND_ROBIN_EN
        m_own = (req0 && req1) ? m_ptr : (req1 ? 1 : 0);
`else
        m_own = req0 ? 0 : 1;
`endif
        m_tg = cyc; m_tb = -1; m_td = -1;
        m_byte = (m_own == 1) ? data1 : data0;
      end
    end else if (m_td >= 0) begin
      m_ptr = (m_own == 0) ? 1 : 0;
      m_own = -1;
    end else if (m_tb >= 0) begin
      if (txDone) m_td = cyc;
    end else if (txBusy) begin
      m_tb = cyc;
    end else if (cyc - 1 - m_tg == ST) begin
      m_own = -1; m_err_at = cyc;
    end
  end

  int run = 0, n_ack0 = 0, n_ack1 = 0, n_err = 0;
  always @(negedge clk) begin
    if (m_en) begin
      bit in_start, in_send;
      in_start = (m_own >= 0) && (m_tb < 0);
      in_send  = (m_tb >= 0) && (m_td < 0);
      chk("grant",   int'(grant),   (m_own < 0) ? 0 : (1 << m_own));
      chk("txEn",    int'(txEn),    int'(in_start | in_send));
      chk("txStart", int'(txStart), int'(in_start && (cyc - m_tg) < ST));
      chk("txByte",  int'(txByte),  int'(m_byte));
      chk("ack0",    int'(ack0),    int'(m_td == cyc && m_own == 0));
      chk("ack1",    int'(ack1),    int'(m_td == cyc && m_own == 1));
      chk("err",     int'(err),     int'(m_err_at == cyc));
      if (txStart) begin
        run++;
        chk("txStart_len_le_timeout", int'(run <= ST), 1);
      end else run = 0;
      n_ack0 += int'(ack0); n_ack1 += int'(ack1); n_err += int'(err);
    end
  end

  // Uart8 stand-in: busy bd+1 cycles after txStart, frame of fl cycles, one-cycle done.
  logic [7:0] frames[$];
  int rs = 0, rc = 0, bd = 2, fl = 8;
  bit resp_en = 1;
  always @(negedge clk) begin
    if (grant == 2'b00 && (rs == 1 || rs == 2)) begin
      rs = 0; r_busy = 1'b0;
    end else begin
      case (rs)
        0: begin r_done = 1'b0; if (resp_en && txStart) begin rs = 1; rc = bd; end end
        1: if (rc == 0) begin r_busy = 1'b1; frames.push_back(txByte); rs = 2; rc = fl; end else rc--;
        2: if (rc == 0) begin r_busy = 1'b0; r_done = 1'b1; rs = 3; end else rc--;
        default: begin r_done = 1'b0; rs = 0; end
      endcase
    end
  end

  task automatic wait_acks(input int n, input int maxc);
    int got = 0;
    for (int i = 0; i < maxc && got < n; i++) begin
      @(negedge clk);
      got += int'(ack0) + int'(ack1);
    end
    chk("ack_wait", got, n);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); @(negedge clk); reset = 1'b0;
  endtask

  logic [7:0] exp4 [4];
  int a0, a1, t0;

  initial begin
    // reset values
    @(negedge clk); @(negedge clk);
    chk("rst_grant", int'(grant), 0);
    chk("rst_txByte", int'(txByte), 0);
    chk("rst_txEn", int'(txEn | txStart), 0);
    reset = 1'b0;

    // single byte from requester 0
    @(negedge clk); frames.delete(); a0 = n_ack0;
    req0 = 1'b1; data0 = 8'h7A;
    @(negedge clk);
    chk("s1_grant", int'(grant), 1);
    chk("s1_byte", int'(txByte), 8'h7A);
    wait_acks(1, 200); req0 = 1'b0;
    repeat (4) @(negedge clk);
    chk("s1_frames", frames.size(), 1);
    if (frames.size() > 0) chk("s1_frame0", int'(frames[0]), 8'h7A);
    chk("s1_ack0", n_ack0 - a0, 1);

    // txBusy/txDone while idle have no effect
    f_busy = 1'b1; f_done = 1'b1;
    repeat (3) @(negedge clk);
    f_busy = 1'b0; f_done = 1'b0;
    chk("idle_grant", int'(grant), 0);

    // contention, pointer fresh from reset
    do_reset(); frames.delete();
    data0 = 8'hB1; data1 = 8'h3C; req0 = 1'b1; req1 = 1'b1;
    wait_acks(4, 400); req0 = 1'b0; req1 = 1'b0;
    repeat (4) @(negedge clk);
`ifdef UART_TX_ARB_ROUND_ROBIN_EN
    exp4 = '{8'hB1, 8'h3C, 8'hB1, 8'h3C};
`else
    exp4 = '{8'hB1, 8'hB1, 8'hB1, 8'hB1};
`endif
    chk("s2_frames", frames.size(), 4);
    for (int i = 0; i < 4 && i < frames.size(); i++) chk("s2_frame", int'(frames[i]), int'(exp4[i]));

    // requester 1 pulses its request for one cycle only
    frames.delete(); a1 = n_ack1;
    data1 = 8'h55; req1 = 1'b1;
    @(negedge clk); req1 = 1'b0;
    wait_acks(1, 200);
    repeat (4) @(negedge clk);
    chk("s3_frames", frames.size(), 1);
    if (frames.size() > 0) chk("s3_frame0", int'(frames[0]), 8'h55);
    chk("s3_ack1", n_ack1 - a1, 1);

    // start timeout: Uart8 never goes busy
    resp_en = 0; a0 = n_ack0; t0 = -1;
    req0 = 1'b1; data0 = 8'h11;
    for (int i = 0; i < 10 && t0 < 0; i++) begin @(negedge clk); if (txStart) t0 = cyc; end
    chk("s4_started", int'(t0 >= 0), 1);
    begin
      int te = -1;
      for (int i = 0; i < 40 && te < 0; i++) begin @(negedge clk); if (err) te = cyc; end
      req0 = 1'b0;
      chk("s4_err_delay", te - t0, 17);
    end
    @(negedge clk);
    chk("s4_grant", int'(grant), 0);
    chk("s4_no_ack", n_ack0 - a0, 0);
    chk("s4_err_count", n_err, 1);
    resp_en = 1;

    // reset during SEND
    a0 = n_ack0; req0 = 1'b1; data0 = 8'h99;
    begin
      bit seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin @(negedge clk); seen = r_busy; end
      chk("s5_reached_send", int'(seen), 1);
    end
    reset = 1'b1; req0 = 1'b0;
    @(negedge clk); reset = 1'b0;
    chk("s5_grant", int'(grant), 0);
    chk("s5_tx", int'({txEn, txStart}), 0);
    chk("s5_byte", int'(txByte), 0);
    repeat (20) @(negedge clk);
    chk("s5_no_ack", n_ack0 - a0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
